viterbi_frame_arbiter: RTL and testbench
========================================

# viterbi_frame_arbiter

Shares one Viterbi decode path (PISO → viterbi_core → SIPO) between NCH input channels, each buffered by its own sync_fifo of 16-bit words. Grants whole frames round-robin. Appends FLUSH_WORDS zero words after each frame so the trellis is terminated before the next channel is switched in. Tags every issued word, so decoded bytes leave with their channel ID, flush bytes are removed, and the last byte of each frame is marked.

## Interface
Parameters:
- NCH, 4, number of requesting channels (2..8)
- CW, 2, channel-ID width, equal to clog2(NCH)
- LEN_W, 8, frame-length field width, in 16-bit words
- FLUSH_WORDS, 4, zero words appended per frame (TBL/8, with TBL=32)
- TAG_DEPTH, 16, depth of the in-flight tag FIFO (power of 2)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_i  in  NCH  channel c has a complete frame waiting in its FIFO
- len_i  in  NCH*LEN_W  frame length of channel c, bits [c*LEN_W +: LEN_W]; sampled at grant
- rd_en_o  out  NCH  one-cycle pop strobe to channel FIFO c
- rd_data_i  in  NCH*16  FIFO read data; valid in the cycle after rd_en_o
- done_o  out  NCH  one-cycle pulse when channel c's frame, including flush, has been fully issued
- dec_ready_i  in  1  decoder accepts a word (PISO not busy)
- dec_valid_o  out  1  one-cycle word strobe to the PISO load input
- dec_data_o  out  16  word to the decoder
- dec_byte_valid_i  in  1  SIPO byte_ready
- dec_byte_i  in  8  SIPO parallel byte
- out_valid_o  out  1  tagged decoded byte is valid
- out_data_o  out  8  decoded byte
- out_chan_o  out  CW  channel of out_data_o
- out_last_o  out  1  last data byte of the frame
- overflow_o  out  1  sticky error flag: a byte arrived while the tag FIFO was empty

## Operation
- Downstream contract: the decoder emits exactly one byte per accepted word, in order.
- Input FSM states: IDLE, READ, CAPT, ISSUE, GUARD, FLUSH, DONE.
- IDLE: if req_i is nonzero, grant the first requesting channel searching from rr_ptr upward, with wrap.
  - Latch the channel ID and len.
  - If len = 0, go to DONE. Otherwise go to READ.
- READ: wait until dec_ready_i = 1 and the tag FIFO is not full. Then pulse rd_en_o[ch] and go to CAPT.
- CAPT: register rd_data_i[ch], then go to ISSUE.
- ISSUE: drive dec_valid_o = 1 with the registered word, and push tag {flush=0, last=(remaining=1), chan}. Decrement remaining, then go to GUARD.
- GUARD: ignore dec_ready_i for 2 cycles, which covers the PISO busy rise delay.
  - If remaining > 0, go to READ.
  - Otherwise, if the flush count is below FLUSH_WORDS, go to FLUSH.
  - Otherwise, go to DONE.
- FLUSH: wait until dec_ready_i = 1 and the tag FIFO is not full. Then drive dec_valid_o with dec_data_o = 0 and push tag {flush=1}. Increment the flush count and go to GUARD.
- DONE: pulse done_o[ch], set rr_ptr = ch+1 mod NCH, clear the counters, and return to IDLE.
- req_i is ignored everywhere except IDLE. len_i changes after grant have no effect.
- Output side, independent of the FSM: on dec_byte_valid_i, pop one tag.
  - If the tag has flush = 1, drop the byte.
  - Otherwise, one cycle later drive out_valid_o = 1 with out_data_o = the byte, plus out_chan_o and out_last_o taken from the tag.
  - If the tag FIFO is empty, drop the byte and set overflow_o = 1. overflow_o clears only on reset.
- A push and a pop in the same cycle are both honoured, and the tag count is unchanged.
- Tag FIFO full blocks issue only. It never drops a tag.

## Timing
- Reset: every output is 0 and dec_data_o = 0. Reset also sets FSM = IDLE, rr_ptr = 0, and empties the tag FIFO.
- Reset mid-frame aborts the frame without a done_o pulse. Words already popped from the channel FIFOs are lost.
- Grant: req_i sampled high in IDLE at cycle T gives rd_en_o high at T+1 at the earliest, provided dec_ready_i was high at T+1.
- Word path: rd_en_o at cycle t, word captured at t+1, dec_valid_o at t+2.
- Minimum spacing between dec_valid_o pulses is 5 cycles: ISSUE, 2×GUARD, READ, CAPT.
- rd_en_o and dec_valid_o are each exactly one cycle wide. Only one rd_en_o bit is high at a time.
- The output byte appears 1 cycle after dec_byte_valid_i.
- Per frame of L words: L data dec_valid_o pulses, then FLUSH_WORDS zero pulses, then done_o one cycle after the last GUARD.

## Test plan
- Channel 0 only, len=3, words 0xA5A5, 0x0F0F, 0xFFFF, dec_ready_i tied high:
  - dec_valid_o sequence is A5A5, 0F0F, FFFF, 0000×4.
  - done_o[0] pulses once.
  - A decoder model echoing each word's low byte gives out bytes A5, 0F, FF with out_chan_o = 0, out_last_o only on FF, and no flush bytes.
- All 4 channels request continuously with len=1:
  - Grant order is 0, 1, 2, 3, 0, …
  - Every frame is followed by 4 flush words.
  - out_chan_o follows the same order.
- Channel 2 with len=0:
  - done_o[2] pulses.
  - No rd_en_o, no dec_valid_o.
  - rr_ptr advances to 3.
- dec_ready_i held low for 20 cycles mid-frame:
  - No rd_en_o and no dec_valid_o during that time.
  - Issue resumes within 2 cycles of ready rising.
  - The data sequence stays intact.
- Withhold dec_byte_valid_i until 16 tags are pending:
  - Issue stalls with 16 tags pending.
  - An extra dec_byte_valid_i pulse with the tag FIFO empty sets overflow_o and it stays set.
- Assert rst_n low during the 2nd word of a len=5 frame:
  - All outputs drop to 0 asynchronously.
  - After release, channel 0 is granted first.

Source files
------------

// File: rtl/viterbi_frame_arbiter.sv
// viterbi_frame_arbiter: round-robin frame arbiter sharing one Viterbi decode path between NCH channel FIFOs
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   req_i, len_i                        per-channel frame request and length (words)
//   rd_en_o, rd_data_i                  channel FIFO pop strobe and data (valid the cycle after the pop)
//   done_o                              per-channel pulse once a frame and its flush words are issued
//   dec_ready_i, dec_valid_o, dec_data_o   word handshake into the decoder PISO
//   dec_byte_valid_i, dec_byte_i        decoded byte from the SIPO
//   out_valid_o, out_data_o, out_chan_o, out_last_o   tagged decoded byte stream
//   overflow_o                          sticky: byte arrived with no pending tag
module viterbi_frame_arbiter #(
  parameter int NCH         = 4,
  parameter int CW          = 2,
  parameter int LEN_W       = 8,
  parameter int FLUSH_WORDS = 4,
  parameter int TAG_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       req_i,
  input  logic [NCH*LEN_W-1:0] len_i,
  output logic [NCH-1:0]       rd_en_o,
  input  logic [NCH*16-1:0]    rd_data_i,
  output logic [NCH-1:0]       done_o,
  input  logic                 dec_ready_i,
  output logic                 dec_valid_o,
  output logic [15:0]          dec_data_o,
  input  logic                 dec_byte_valid_i,
  input  logic [7:0]           dec_byte_i,
  output logic                 out_valid_o,
  output logic [7:0]           out_data_o,
  output logic [CW-1:0]        out_chan_o,
  output logic                 out_last_o,
  output logic                 overflow_o
);
  localparam int AW = $clog2(TAG_DEPTH);
  localparam int FW = $clog2(FLUSH_WORDS + 1);
  localparam int TW = CW + 2;
  localparam logic [AW:0] TAG_FULL = TAG_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, READ, CAPT, ISSUE, GUARD, FLUSH, DONE} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_ch, r_rr, w_gnt;
  logic w_found;
  logic [LEN_W-1:0] r_rem, w_len;
  logic [FW-1:0] r_fcnt;
  logic r_gcnt;
  logic [15:0] r_word;
  // tag layout: {flush, last, chan}
  logic [TW-1:0] r_tag [TAG_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_full, w_empty, w_go, w_push, w_pop;
  logic [TW-1:0] w_tag_in, w_tag_out;
  logic r_out_valid, r_out_last, r_ovf;
  logic [7:0] r_out_data;
  logic [CW-1:0] r_out_chan;
  assign w_full    = r_cnt == TAG_FULL;
  assign w_empty   = r_cnt == '0;
  assign w_go      = dec_ready_i && !w_full;
  assign w_pop     = dec_byte_valid_i && !w_empty;
  assign w_tag_out = r_tag[r_rp];
  assign w_len     = len_i[int'(w_gnt)*LEN_W +: LEN_W];
  // first requester at or above the round-robin pointer, wrapping
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!w_found && req_i[CW'((int'(r_rr) + i) % NCH)]) begin
        w_found = 1'b1;
        w_gnt   = CW'((int'(r_rr) + i) % NCH);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next      = r_state;
    rd_en_o     = '0;
    done_o      = '0;
    dec_valid_o = 1'b0;
    dec_data_o  = '0;
    w_push      = 1'b0;
    w_tag_in    = '0;
    case (r_state)
      IDLE:  if (w_found) w_next = (w_len == '0) ? DONE : READ;
      READ:  if (w_go) begin
        rd_en_o[r_ch] = 1'b1;
        w_next        = CAPT;
      end
      CAPT:  w_next = ISSUE;
      ISSUE: begin
        dec_valid_o = 1'b1;
        dec_data_o  = r_word;
        w_push      = 1'b1;
        w_tag_in    = {1'b0, r_rem == LEN_W'(1), r_ch};
        w_next      = GUARD;
      end
      // two dead cycles hide the PISO busy rise delay
      GUARD: if (r_gcnt) w_next = (r_rem != '0) ? READ : (r_fcnt < FW'(FLUSH_WORDS)) ? FLUSH : DONE;
      FLUSH: if (w_go) begin
        dec_valid_o = 1'b1;
        w_push      = 1'b1;
        w_tag_in    = {1'b1, 1'b0, r_ch};
        w_next      = GUARD;
      end
      DONE: begin
        done_o[r_ch] = 1'b1;
        w_next       = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch   <= '0;
      r_rr   <= '0;
      r_rem  <= '0;
      r_fcnt <= '0;
      r_gcnt <= 1'b0;
      r_word <= '0;
    end else begin
      if (r_state == IDLE && w_found) begin
        r_ch  <= w_gnt;
        r_rem <= w_len;
      end
      if (r_state == CAPT) r_word <= rd_data_i[int'(r_ch)*16 +: 16];
      if (r_state == ISSUE) r_rem <= r_rem - LEN_W'(1);
      if (r_state == FLUSH && w_go) r_fcnt <= r_fcnt + FW'(1);
      r_gcnt <= (r_state == GUARD) && !r_gcnt;
      if (r_state == DONE) begin
        r_rr   <= (r_ch == CW'(NCH - 1)) ? '0 : r_ch + CW'(1);
        r_fcnt <= '0;
        r_rem  <= '0;
      end
    end
  end
  // a push is only ever issued after READ/FLUSH saw room, so it never overruns
  always_ff @(posedge clk)
    if (w_push) r_tag[r_wp] <= w_tag_in;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_push);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_out_last  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_out_valid <= w_pop && !w_tag_out[TW-1];
      if (w_pop && !w_tag_out[TW-1]) begin
        r_out_data <= dec_byte_i;
        r_out_chan <= w_tag_out[CW-1:0];
        r_out_last <= w_tag_out[CW];
      end
      if (dec_byte_valid_i && w_empty) r_ovf <= 1'b1;
    end
  end
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_chan_o  = r_out_chan;
  assign out_last_o  = r_out_last;
  assign overflow_o  = r_ovf;
endmodule

// File: tb/tb_viterbi_frame_arbiter.sv
// tb_viterbi_frame_arbiter: directed and randomized checks of the frame arbiter against a frame-level model
module tb_viterbi_frame_arbiter;
  localparam int NCH = 4;
  localparam int CW  = 2;
  localparam int LW  = 8;
  localparam int FL  = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCH-1:0] req_i = '0;
  logic [NCH*LW-1:0] len_i = '0;
  logic [NCH-1:0] rd_en_o;
  logic [NCH*16-1:0] rd_data_i = '0;
  logic [NCH-1:0] done_o;
  logic dec_ready_i = 1'b0;
  logic dec_valid_o;
  logic [15:0] dec_data_o;
  logic dec_byte_valid_i = 1'b0;
  logic [7:0] dec_byte_i = '0;
  logic out_valid_o;
  logic [7:0] out_data_o;
  logic [CW-1:0] out_chan_o;
  logic out_last_o;
  logic overflow_o;
  viterbi_frame_arbiter #(.NCH(NCH), .CW(CW), .LEN_W(LW), .FLUSH_WORDS(FL), .TAG_DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .len_i(len_i), .rd_en_o(rd_en_o), .rd_data_i(rd_data_i),
    .done_o(done_o), .dec_ready_i(dec_ready_i), .dec_valid_o(dec_valid_o), .dec_data_o(dec_data_o),
    .dec_byte_valid_i(dec_byte_valid_i), .dec_byte_i(dec_byte_i), .out_valid_o(out_valid_o),
    .out_data_o(out_data_o), .out_chan_o(out_chan_o), .out_last_o(out_last_o), .overflow_o(overflow_o)
  );
  always #5 clk = ~clk;
  logic [15:0] wmem [NCH][512];
  int flen [NCH][64];
  int wr_ix [NCH], rd_ix [NCH], ftl [NCH], fhd [NCH], mrd [NCH], mhd [NCH];
  int mptr;
  logic [15:0] exp_dv [$], obs_dv [$];
  int exp_done [$], obs_done [$];
  logic [10:0] exp_out [$], obs_out [$];
  int rd_cycs [$], dv_cycs [$], done_cycs [$];
  logic [7:0] dq [$];
  int cyc, lowev, onehot_bad, rise_cyc, req_cyc, extra_req, extra_done, rdy_mode;
  bit dec_en, dec_rand;
  int n_vec, n_err;
  // environment: channel FIFOs, request/length presentation, decoder echoing each word's low byte
  always @(negedge clk) begin
    logic [NCH-1:0] old_req;
    cyc++;
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        rd_ix[c] = wr_ix[c];
        fhd[c]   = ftl[c];
      end
      dq.delete();
      req_i = '0;
      len_i = '0;
      dec_byte_valid_i = 1'b0;
    end else begin
      if ($countones(rd_en_o) > 1) onehot_bad++;
      if (!dec_ready_i && (rd_en_o != '0 || dec_valid_o)) lowev++;
      for (int c = 0; c < NCH; c++)
        if (rd_en_o[c]) begin
          rd_data_i[c*16 +: 16] = wmem[c][rd_ix[c]];
          rd_ix[c]++;
          rd_cycs.push_back(cyc);
        end
      if (dec_valid_o) begin
        obs_dv.push_back(dec_data_o);
        dv_cycs.push_back(cyc);
      end
      for (int c = 0; c < NCH; c++)
        if (done_o[c]) begin
          obs_done.push_back(c);
          done_cycs.push_back(cyc);
          fhd[c]++;
        end
      if (out_valid_o) obs_out.push_back({out_last_o, out_chan_o, out_data_o});
      dec_byte_valid_i = 1'b0;
      if (extra_req != extra_done) begin
        dec_byte_valid_i = 1'b1;
        dec_byte_i = 8'h5A;
        extra_done++;
      end else if (dec_en && dq.size() > 0 && (!dec_rand || $urandom_range(0, 1) == 1)) begin
        dec_byte_valid_i = 1'b1;
        dec_byte_i = dq.pop_front();
      end
      if (dec_valid_o) dq.push_back(dec_data_o[7:0]);
      old_req = req_i;
      for (int c = 0; c < NCH; c++) begin
        req_i[c] = fhd[c] != ftl[c];
        len_i[c*LW +: LW] = (fhd[c] != ftl[c]) ? LW'(flen[c][fhd[c]]) : '0;
      end
      if (old_req == '0 && req_i != '0) req_cyc = cyc;
    end
  end
  // ready changes just after the rising edge so combinational outputs are settled at the sample point
  always @(posedge clk) begin
    logic nr;
    #1;
    nr = (rdy_mode == 0) ? 1'b0 : (rdy_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    if (nr && !dec_ready_i) rise_cyc = cyc + 1;
    dec_ready_i = nr;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic add_word(input int c, input logic [15:0] w);
    wmem[c][wr_ix[c]] = w;
    wr_ix[c]++;
  endtask
  task automatic end_frame(input int c, input int len);
    flen[c][ftl[c]] = len;
    ftl[c]++;
  endtask
  task automatic add_rand(input int c, input int len);
    for (int i = 0; i < len; i++) add_word(c, 16'($urandom));
    end_frame(c, len);
  endtask
  // frame-level model: pick frames round-robin, emit words + flush zeros, bytes tagged with channel/last
  task automatic build();
    int c;
    int len;
    bit more;
    more = 1'b1;
    while (more) begin
      c = -1;
      for (int i = 0; i < NCH; i++) begin
        int k;
        k = (mptr + i) % NCH;
        if (c < 0 && mhd[k] != ftl[k]) c = k;
      end
      if (c < 0) more = 1'b0;
      else begin
        len = flen[c][mhd[c]];
        mhd[c]++;
        for (int i = 0; i < len; i++) begin
          logic [15:0] w;
          w = wmem[c][mrd[c]];
          mrd[c]++;
          exp_dv.push_back(w);
          exp_out.push_back({i == len - 1, 2'(c), w[7:0]});
        end
        if (len > 0) repeat (FL) exp_dv.push_back(16'h0000);
        exp_done.push_back(c);
        mptr = (c + 1) % NCH;
      end
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    exp_dv.delete(); obs_dv.delete();
    exp_done.delete(); obs_done.delete();
    exp_out.delete(); obs_out.delete();
    rd_cycs.delete(); dv_cycs.delete(); done_cycs.delete();
    mptr = 0;
    for (int c = 0; c < NCH; c++) begin
      mhd[c] = ftl[c];
      mrd[c] = wr_ix[c];
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    while (t < 8000 && !(obs_dv.size() == exp_dv.size() && obs_done.size() == exp_done.size()
                         && obs_out.size() == exp_out.size())) begin
      @(posedge clk);
      t++;
    end
    repeat (12) @(posedge clk);
    chk({tag, "_timeout"}, 64'(t < 8000), 64'd1);
  endtask
  task automatic cmp_all(input string tag);
    chk({tag, "_ndv"}, obs_dv.size(), exp_dv.size());
    for (int i = 0; i < obs_dv.size() && i < exp_dv.size(); i++) chk({tag, "_dv"}, obs_dv[i], exp_dv[i]);
    chk({tag, "_ndone"}, obs_done.size(), exp_done.size());
    for (int i = 0; i < obs_done.size() && i < exp_done.size(); i++) chk({tag, "_done"}, obs_done[i], exp_done[i]);
    chk({tag, "_nout"}, obs_out.size(), exp_out.size());
    for (int i = 0; i < obs_out.size() && i < exp_out.size(); i++) chk({tag, "_out"}, obs_out[i], exp_out[i]);
    chk({tag, "_onehot"}, onehot_bad, 0);
  endtask
  function automatic logic [63:0] all_outs();
    return 64'({rd_en_o, done_o, dec_valid_o, dec_data_o, out_valid_o, out_data_o, out_chan_o, out_last_o, overflow_o});
  endfunction
  initial begin
    int seen;
    int t;
    int d;
    dec_en = 1'b1;
    dec_rand = 1'b0;
    rdy_mode = 1;
    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    // single channel, len 3, ready high
    do_reset();
    add_word(0, 16'hA5A5); add_word(0, 16'h0F0F); add_word(0, 16'hFFFF);
    end_frame(0, 3);
    build();
    wait_idle("ch0");
    cmp_all("ch0");
    chk("ch0_w0", obs_dv[0], 16'hA5A5);
    chk("ch0_lastbyte", obs_out[2], {1'b1, 2'd0, 8'hFF});
    chk("ch0_grant_lat", rd_cycs[0] - req_cyc, 1);
    for (int i = 1; i < 3; i++) chk("ch0_data_gap", dv_cycs[i] - dv_cycs[i-1], 5);
    for (int i = 3; i < 7; i++) chk("ch0_flush_gap", dv_cycs[i] - dv_cycs[i-1], 3);
    chk("ch0_done_lat", done_cycs[0] - dv_cycs[6], 3);
    // four channels, two len-1 frames each
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NCH; c++) add_rand(c, 1);
    build();
    wait_idle("rr");
    cmp_all("rr");
    for (int i = 0; i < 8; i++) chk("rr_order", obs_done[i], i % NCH);
    // zero-length frame on channel 2, then pointer must sit at 3
    do_reset();
    end_frame(2, 0);
    build();
    wait_idle("len0");
    chk("len0_rd", rd_cycs.size(), 0);
    chk("len0_dv", obs_dv.size(), 0);
    chk("len0_done", obs_done[0], 2);
    add_rand(0, 1);
    add_rand(3, 1);
    build();
    wait_idle("len0b");
    cmp_all("len0b");
    chk("len0_next", obs_done[1], 3);
    // ready held low mid-frame
    do_reset();
    add_rand(1, 4);
    build();
    t = 0;
    while (obs_dv.size() < 1 && t < 500) begin
      @(posedge clk);
      t++;
    end
    chk("stall_start", obs_dv.size(), 1);
    rdy_mode = 0;
    lowev = 0;
    repeat (20) @(posedge clk);
    chk("stall_quiet", lowev, 0);
    chk("stall_dv", obs_dv.size(), 1);
    rdy_mode = 1;
    wait_idle("stall");
    d = 99;
    foreach (rd_cycs[i]) if (d == 99 && rd_cycs[i] >= rise_cyc) d = rd_cycs[i] - rise_cyc;
    chk("stall_resume", 64'(d <= 2), 64'd1);
    cmp_all("stall");
    // randomized traffic, random ready and decoder latency
    do_reset();
    dec_rand = 1'b1;
    rdy_mode = 2;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 2) != 0) add_rand(c, $urandom_range(0, 5));
    build();
    wait_idle("rand");
    cmp_all("rand");
    chk("rand_ovf", overflow_o, 1'b0);
    dec_rand = 1'b0;
    rdy_mode = 1;
    // tag FIFO fill with decoder withheld, then overflow
    do_reset();
    dec_en = 1'b0;
    add_rand(0, 20);
    build();
    repeat (200) @(posedge clk);
    chk("full_stall", obs_dv.size(), 16);
    repeat (30) @(posedge clk);
    chk("full_hold", obs_dv.size(), 16);
    dec_en = 1'b1;
    wait_idle("full");
    cmp_all("full");
    chk("ovf_before", overflow_o, 1'b0);
    extra_req++;
    repeat (3) @(posedge clk);
    chk("ovf_set", overflow_o, 1'b1);
    chk("ovf_nobyte", obs_out.size(), exp_out.size());
    repeat (10) @(posedge clk);
    chk("ovf_sticky", overflow_o, 1'b1);
    // reset during the second word of a len-5 frame
    do_reset();
    add_rand(0, 1);
    build();
    wait_idle("pre");
    cmp_all("pre");
    add_rand(1, 5);
    seen = 0;
    t = 0;
    while (seen < 2 && t < 500) begin
      @(negedge clk);
      t++;
      if (rd_en_o[1]) seen++;
    end
    chk("abort_reached", seen, 2);
    #1 rst_n = 1'b0;
    #1 chk("abort_outputs", all_outs(), 64'd0);
    do_reset();
    add_rand(1, 2);
    add_rand(0, 2);
    build();
    wait_idle("post");
    cmp_all("post");
    chk("post_first", obs_done[0], 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
